// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer between the UART receiver and the host/bus logic.
// Bytes strobed in by the receiver are stored in a DEPTH-entry circular
// buffer and presented to the consumer first-word-fall-through: the head
// byte is visible on rd_data whenever rd_valid is high.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   wr_data/wr_en byte and single-cycle strobe from the receiver
//   flush         synchronous clear of buffer contents (pointers only)
//   rd_ready      consumer takes rd_data this cycle
//   rd_data       byte at head of buffer (combinational read)
//   rd_valid      head byte is valid
//   level         stored byte count, 0..DEPTH
//   empty/full    level == 0 / level == DEPTH
//   almost_full   level >= AF_THRESH
//   overrun       sticky flag, set when a byte is dropped
//   overrun_clr   clears overrun and drop_cnt
//   drop_cnt      saturating count of dropped bytes
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              flush,
  input  logic              rd_ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W + 1)'(AF_THRESH);

  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic            push;
  logic            pop;
  logic            drop;

  // Pointers carry one extra wrap bit so that full and empty are
  // distinguishable without a separate counter.
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (level >= AF_LEVEL);

  assign rd_valid    = !empty;
  assign rd_data     = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // A pop frees a slot in the same edge, so a write into a full buffer is
  // accepted when the consumer is taking the head. A flush swallows any
  // concurrent write without counting it as a drop.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop) && !flush;
  assign drop = wr_en && full && !pop && !flush;

  // Storage and pointer update. Flush only rewinds the pointers; stale
  // memory contents are never visible because rd_valid drops with them.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[ADDR_W-1:0]] = wr_data;
        wr_ptr_d                    = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Overrun bookkeeping. A drop in the same cycle as a clear wins, leaving
  // the flag set and the count restarted at one.
  always_comb begin
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overrun_d = 1'b1;
      if (overrun_clr) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (overrun_clr) begin
      overrun_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: 8'h00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the host/bus logic. Each single-cycle byte strobe from the receiver is captured into a DEPTH-entry circular buffer. Bytes are presented to the consumer through a first-word-fall-through valid/ready interface. The block also reports fill level, almost-full, a sticky overrun flag and a saturating dropped-byte counter.

## Interface
- DEPTH, 16: number of entries; power of two, ≥ 2
- ADDR_W, 4: log2(DEPTH)
- AF_THRESH, 12: almost_full asserts when level ≥ AF_THRESH; range 1..DEPTH
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_data  in  8  received byte; connects to receiver rx_data
- wr_en  in  1  one-cycle byte strobe; connects to receiver data_ready
- flush  in  1  synchronous clear of buffer contents
- rd_ready  in  1  consumer accepts rd_data this cycle
- rd_data  out  8  byte at head of buffer
- rd_valid  out  1  rd_data holds a valid byte
- level  out  ADDR_W+1  number of stored bytes, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_full  out  1  level ≥ AF_THRESH
- overrun  out  1  sticky: at least one byte dropped
- overrun_clr  in  1  clears overrun and drop_cnt
- drop_cnt  out  8  dropped bytes, saturates at 255

## Operation
- Storage: DEPTH×8 register array. wr_ptr and rd_ptr are ADDR_W+1 bits wide, and the MSB is the wrap bit. full is (MSBs differ, low bits equal). empty is (pointers equal). level is wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
- Pop: pop = rd_valid && rd_ready. On pop, rd_ptr increments.
- Push: push = wr_en && (!full || pop). On push, mem[wr_ptr[ADDR_W-1:0]] ← wr_data and wr_ptr increments.
- Full with a simultaneous pop: the write is accepted and level is unchanged.
- Empty with a simultaneous write: rd_valid is low, so there is no pop. The write is accepted and level goes to 1.
- Drop: wr_en && full && !pop. The byte is discarded, overrun is set to 1 and drop_cnt increments (saturating at 255). Memory and pointers are unchanged.
- rd_valid = !empty. rd_data = mem[rd_ptr[ADDR_W-1:0]], read combinationally from the registered array (FWFT).
- flush: wr_ptr and rd_ptr are set to 0 on the next edge.
  - flush overrides push and pop in the same cycle; a concurrent wr_en byte is discarded and not counted as dropped.
  - flush does not alter overrun or drop_cnt.
- overrun_clr: clears overrun and drop_cnt to 0. If a drop occurs in the same cycle, set wins: overrun = 1 and drop_cnt = 1.
- The consumer may hold rd_ready high continuously. rd_ready while empty has no effect.

## Timing
- Reset values (asynchronous): wr_ptr = rd_ptr = 0, all memory entries 0, rd_data = 0x00, rd_valid = 0, level = 0, empty = 1, full = 0, almost_full = 0, overrun = 0, drop_cnt = 0.
- Write-to-read latency: a byte strobed at edge N gives rd_valid = 1 and rd_data = byte immediately after edge N (1 cycle).
- Pop: the head advances at the edge where rd_valid && rd_ready is sampled. The next byte is on rd_data after that edge.
- Status outputs (level, empty, full, almost_full) are derived from registered pointers and update in the same cycle as the pointers.
- Pointer wrap-around is seamless. Sustained push+pop at the wrap boundary must not corrupt data or level.
- Back-to-back wr_en on consecutive cycles is supported at full rate (one byte per cycle), even though the receiver strobes far less often.

## Test plan
- Basic FWFT: write 0xA5 with rd_ready = 0 → next cycle rd_valid = 1, rd_data = 0xA5, level = 1. Assert rd_ready one cycle → empty = 1, level = 0.
- Fill and overrun: write 0x00..0x0F (DEPTH = 16) → full = 1, almost_full asserted at level 12. Write 0x10, 0x11 → overrun = 1, drop_cnt = 2. Drain → rd_data sequence 0x00..0x0F.
- Full with simultaneous push+pop: at full, wr_en = 1 with 0x55 and rd_ready = 1 → level stays 16, overrun stays 0, and 0x55 is read last.
- Wrap-around: 40 bytes streamed with rd_ready tied high, level never above 2 → output order and values identical to input, no drops.
- flush and clear: 5 bytes stored plus a concurrent wr_en and flush → next cycle level = 0, empty = 1, drop_cnt unchanged. overrun_clr in the same cycle as a drop → overrun = 1, drop_cnt = 1.
- Async reset mid-operation: 7 bytes stored, overrun = 1, rst_n pulsed low between clock edges → all outputs at reset values immediately. After release, a write of 0x3C reads back 0x3C.
